// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int N_CORES_DEF  = 8;
  localparam int MAX_LOCK_DEF = 4;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rtl/dmem_arbiter_rr_pick.sv - combinational rotate-and-priority-encode request picker
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pickOneHot,
  output logic [IW-1:0] pickIdx,
  output logic          pickValid
);

  int              slot;
  logic [IW-1:0]   slotIdx;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    pickOneHot = '0;
    pickIdx    = '0;
    pickValid  = 1'b0;
    slot       = 0;
    slotIdx    = '0;
    for (int i = 0; i < N; i++) begin
      slot = int'(ptr) + i;
      if (slot >= N) slot = slot - N;
      slotIdx = IW'(slot);
      if (!pickValid && req[slotIdx]) begin
        pickValid           = 1'b1;
        pickOneHot[slotIdx] = 1'b1;
        pickIdx             = slotIdx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter with bounded grant lock for a shared data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_CORES  = N_CORES_DEF,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CORES-1:0]   req_i,
  input  logic [N_CORES-1:0]   we_i,
  input  logic [N_CORES-1:0]   lock_i,
  input  logic [N_CORES*AW-1:0] addr_i,
  input  logic [N_CORES*DW-1:0] wdata_i,
  output logic [N_CORES-1:0]   gnt_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic [DW-1:0]        mem_rdata_i,
  output logic [DW-1:0]        rdata_o,
  output logic [N_CORES-1:0]   rvalid_o
);

  localparam int IW = idxWidth(N_CORES);
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gntIdx;
  logic [CW-1:0]      lockCnt;

  logic [N_CORES-1:0] pickOneHot;
  logic [IW-1:0]      pickIdx;
  logic               pickValid;

  logic               holdLock;
  logic               nextValid;
  logic [IW-1:0]      nextIdx;
  logic [N_CORES-1:0] nextOneHot;
  logic [CW-1:0]      nextCnt;

  rr_pick #(.N(N_CORES), .IW(IW)) picker (
    .req        (req_i),
    .ptr        (ptr),
    .pickOneHot (pickOneHot),
    .pickIdx    (pickIdx),
    .pickValid  (pickValid)
  );

  // A locked owner keeps the port until its run reaches MAX_LOCK grants;
  // after that the normal round-robin pick (starting past it) takes over.
  always_comb begin
    holdLock   = (|gnt_o) && req_i[gntIdx] && lock_i[gntIdx] &&
                 (lockCnt < CW'(MAX_LOCK - 1));
    nextValid  = pickValid;
    nextIdx    = pickIdx;
    nextOneHot = pickOneHot;
    nextCnt    = '0;
    if (holdLock) begin
      nextValid  = 1'b1;
      nextIdx    = gntIdx;
      nextOneHot = gnt_o;
      nextCnt    = lockCnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      gntIdx      <= '0;
      lockCnt     <= '0;
      gnt_o       <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      rvalid_o    <= '0;
    end else begin
      rvalid_o <= gnt_o;
      if (|gnt_o) rdata_o <= mem_rdata_i;
      gnt_o    <= nextOneHot;
      mem_we_o <= nextValid && we_i[nextIdx];
      lockCnt  <= nextCnt;
      if (nextValid) begin
        gntIdx      <= nextIdx;
        ptr         <= (nextIdx == IW'(N_CORES - 1)) ? '0 : nextIdx + IW'(1);
        mem_addr_o  <= addr_i[nextIdx*AW +: AW];
        mem_wdata_o <= wdata_i[nextIdx*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  typedef struct packed {
    logic [7:0]  gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct packed {
    logic [7:0]  rv;
    logic [31:0] rd;
  } rexp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req_i, we_i, lock_i;
  logic [255:0] addr_i, wdata_i;
  logic [7:0]   gnt_o, rvalid_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o, mem_wdata_o, mem_rdata_i, rdata_o;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g;
  rexp_t r;
  int    passed = 0;
  int    total  = 0;

  dmem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .we_i        (we_i),
    .lock_i      (lock_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addrOf(input int k);
    return 32'(k * 32'h20);
  endfunction

  function automatic logic [31:0] wdataOf(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] rdFor(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // Memory model: address 0x40 holds 0xDEADBEEF, everything else reads ~addr.
  assign mem_rdata_i = rdFor(mem_addr_o);

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input int k, input logic we, input bit withRvalid);
    gexp_t e;
    rexp_t x;
    e.gnt   = 8'(1 << k);
    e.we    = we;
    e.addr  = addrOf(k);
    e.wdata = wdataOf(k);
    gq.push_back(e);
    if (withRvalid) begin
      x.rv = 8'(1 << k);
      x.rd = rdFor(addrOf(k));
      rq.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (gnt_o != 8'h00) begin
      if (gq.size() == 0) begin
        check("unexpected_grant", 1'b0, gnt_o, 64'h0);
      end else begin
        g = gq.pop_front();
        check("gnt", gnt_o == g.gnt, gnt_o, g.gnt);
        check("mem_we", mem_we_o == g.we, mem_we_o, g.we);
        check("mem_addr", mem_addr_o == g.addr, mem_addr_o, g.addr);
        check("mem_wdata", mem_wdata_o == g.wdata, mem_wdata_o, g.wdata);
      end
    end
    if (rvalid_o != 8'h00) begin
      if (rq.size() == 0) begin
        check("unexpected_rvalid", 1'b0, rvalid_o, 64'h0);
      end else begin
        r = rq.pop_front();
        check("rvalid", rvalid_o == r.rv, rvalid_o, r.rv);
        check("rdata", rdata_o == r.rd, rdata_o, r.rd);
      end
    end
    if (mem_we_o) check("we_needs_onehot_gnt", $onehot(gnt_o), gnt_o, 64'h1);
  end

  task automatic checkAllZero(input string tag);
    check({tag, "_gnt"}, gnt_o == 8'h00, gnt_o, 64'h0);
    check({tag, "_mem_we"}, mem_we_o == 1'b0, mem_we_o, 64'h0);
    check({tag, "_mem_addr"}, mem_addr_o == 32'h0, mem_addr_o, 64'h0);
    check({tag, "_mem_wdata"}, mem_wdata_o == 32'h0, mem_wdata_o, 64'h0);
    check({tag, "_rdata"}, rdata_o == 32'h0, rdata_o, 64'h0);
    check({tag, "_rvalid"}, rvalid_o == 8'h00, rvalid_o, 64'h0);
  endtask

  initial begin
    reset  = 1'b1;
    req_i  = '0;
    we_i   = '0;
    lock_i = '0;
    for (int k = 0; k < 8; k++) begin
      addr_i[k*32 +: 32]  = addrOf(k);
      wdata_i[k*32 +: 32] = wdataOf(k);
    end
    repeat (3) tick;
    checkAllZero("reset");
    reset = 1'b0;

    // All cores writing, no lock: one grant per cycle 0..7 then wrap to 0.
    req_i = 8'hFF;
    we_i  = 8'hFF;
    for (int k = 0; k < 9; k++) expectGrant(k % 8, 1'b1, 1'b1);
    repeat (9) tick;
    req_i = 8'h00;
    we_i  = 8'h00;

    // Idle stretch, then the pointer (1) resumes.
    repeat (10) begin
      tick;
      check("idle_gnt", gnt_o == 8'h00, gnt_o, 64'h0);
      check("idle_we", mem_we_o == 1'b0, mem_we_o, 64'h0);
    end
    req_i = 8'h03;
    expectGrant(1, 1'b0, 1'b1);
    expectGrant(0, 1'b0, 1'b1);
    tick;
    req_i = 8'h01;
    tick;

    // Move pointer to 7, then 7 wins before wrapping to 0.
    req_i = 8'h40;
    expectGrant(6, 1'b0, 1'b1);
    expectGrant(7, 1'b0, 1'b1);
    expectGrant(0, 1'b0, 1'b1);
    tick;
    req_i = 8'h81;
    tick;
    req_i = 8'h01;
    tick;

    // Core 2 reads 0x40.
    req_i = 8'h04;
    expectGrant(2, 1'b0, 1'b1);
    tick;
    check("rd_gnt", gnt_o == 8'h04, gnt_o, 64'h04);
    req_i = 8'h00;
    tick;
    check("rd_rvalid", rvalid_o == 8'h04, rvalid_o, 64'h04);
    check("rd_rdata", rdata_o == 32'hDEAD_BEEF, rdata_o, 64'hDEAD_BEEF);

    // Core 3 locked with core 5 competing: four grants to 3, then 5.
    req_i  = 8'h28;
    lock_i = 8'h08;
    for (int i = 0; i < 4; i++) expectGrant(3, 1'b0, 1'b1);
    expectGrant(5, 1'b0, 1'b1);
    repeat (5) tick;
    req_i  = 8'h00;
    lock_i = 8'h00;

    // Core 3 locked alone: keeps the port past MAX_LOCK.
    req_i  = 8'h08;
    lock_i = 8'h08;
    we_i   = 8'h08;
    for (int i = 0; i < 6; i++) expectGrant(3, 1'b1, 1'b1);
    repeat (6) tick;
    req_i  = 8'h00;
    lock_i = 8'h00;

    // Reset mid-lock of core 6; the second grant's read return is cut by reset.
    req_i  = 8'h40;
    lock_i = 8'h40;
    we_i   = 8'h40;
    expectGrant(6, 1'b1, 1'b1);
    expectGrant(6, 1'b1, 1'b0);
    tick;
    tick;
    reset = 1'b1;
    tick;
    checkAllZero("midlock_reset");
    reset  = 1'b0;
    req_i  = 8'h41;
    lock_i = 8'h00;
    we_i   = 8'h00;
    expectGrant(0, 1'b0, 1'b1);
    tick;
    check("post_reset_gnt", gnt_o == 8'h01, gnt_o, 64'h01);
    req_i = 8'h00;
    repeat (3) tick;

    check("grants_drained", gq.size() == 0, 64'(gq.size()), 64'h0);
    check("rvalids_drained", rq.size() == 0, 64'(rq.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
